aes_enc_round_ctrl: RTL and testbench

//  Sequencer for an iterative AES-128 encryption engine: accepts one plaintext/key pair over a

---
 rtl/aes_enc_round_ctrl_pkg.sv | 33 +++
 rtl/aes_enc_round_ctrl.sv | 117 +++++++++++
 tb/tb_aes_enc_round_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_enc_round_ctrl_pkg.sv
// Shared definitions for the iterative AES-128 encryption sequencer:
// round count, controller state encodings and the Rcon lookup. The Rcon
// helper is also meant for the external key-expansion step.
package aes_enc_round_ctrl_pkg;

   localparam int AES_NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } aes_state_e;

   // Rcon byte for rounds 1..10; anything else reads 0
   function automatic logic [7:0] aes_rcon(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption sequencer. Takes one plaintext/key pair,
// applies the initial AddRoundKey, then steps an external combinational
// round datapath and key-expansion step once per clock for NR rounds and
// presents the ciphertext until the consumer takes it.
// Vectors are packed with bit DW-1 holding FIPS-197 bit 0 (MSB-first bytes).
// Optional: define AES_ENC_CTRL_BLKCNT_EN to add the blk_cnt completed-block
// counter output.
module aes_enc_round_ctrl
   import aes_enc_round_ctrl_pkg::*;
#(
   parameter int NR = AES_NR,   // only 10 is supported
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] plaintext,
   input  logic [DW-1:0] key,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] encrypted,
   output logic [DW-1:0] rnd_state_o,
   output logic [DW-1:0] rnd_key_o,
   output logic          rnd_last_o,
   input  logic [DW-1:0] rnd_result_i,
   output logic [DW-1:0] ks_key_o,
   output logic [7:0]    ks_rcon_o,
`ifdef AES_ENC_CTRL_BLKCNT_EN
   output logic [31:0]   blk_cnt,
`endif
   input  logic [DW-1:0] ks_next_i
);

   aes_state_e    fsm_q, fsm_d;
   logic [DW-1:0] state_q;
   logic [DW-1:0] rkey_q;
   logic [3:0]    round_q;
   logic          last_rnd;

   assign last_rnd = (round_q == 4'(NR));

   // controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= ST_IDLE;
      else        fsm_q <= fsm_d;
   end

   // next state and all handshake/datapath-facing outputs; the external
   // datapath sees zeros unless a round is actually in progress
   always_comb begin
      fsm_d       = fsm_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      encrypted   = '0;
      rnd_state_o = '0;
      rnd_key_o   = '0;
      rnd_last_o  = 1'b0;
      ks_key_o    = '0;
      ks_rcon_o   = 8'h00;
      case (fsm_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) fsm_d = ST_ROUND;
         end
         ST_ROUND: begin
            ks_key_o    = rkey_q;
            ks_rcon_o   = aes_rcon(round_q);
            rnd_state_o = state_q;
            rnd_key_o   = ks_next_i;
            rnd_last_o  = last_rnd;
            if (last_rnd) fsm_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            encrypted = state_q;
            if (out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // block state, round key and round counter; the counter is cleared on
   // the last round so it never goes past NR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         rkey_q  <= '0;
         round_q <= 4'd0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (in_valid) begin
                  state_q <= plaintext ^ key;
                  rkey_q  <= key;
                  round_q <= 4'd1;
               end
            end
            ST_ROUND: begin
               state_q <= rnd_result_i;
               rkey_q  <= ks_next_i;
               round_q <= last_rnd ? 4'd0 : round_q + 4'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef AES_ENC_CTRL_BLKCNT_EN
   // completed-block counter, wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       blk_cnt <= 32'd0;
      else if (out_valid && out_ready)  blk_cnt <= blk_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: attaches behavioural AES round and
// key-expansion models, drives FIPS-197 vectors and checks ciphertexts
// through an expected-result queue. Covers blk_cnt when
// AES_ENC_CTRL_BLKCNT_EN is defined.
module tb_aes_enc_round_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] plaintext, key, encrypted;
   logic [127:0] rnd_state_o, rnd_key_o, rnd_result_i, ks_key_o, ks_next_i;
   logic         rnd_last_o;
   logic [7:0]   ks_rcon_o;
`ifdef AES_ENC_CTRL_BLKCNT_EN
   logic [31:0]  blk_cnt;
`endif

   int           n_assert = 0;
   int           n_fail   = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   rcon_t[10];

   localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes_enc_round_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .plaintext(plaintext), .key(key),
      .out_valid(out_valid), .out_ready(out_ready), .encrypted(encrypted),
      .rnd_state_o(rnd_state_o), .rnd_key_o(rnd_key_o), .rnd_last_o(rnd_last_o),
      .rnd_result_i(rnd_result_i),
      .ks_key_o(ks_key_o), .ks_rcon_o(ks_rcon_o),
`ifdef AES_ENC_CTRL_BLKCNT_EN
      .blk_cnt(blk_cnt),
`endif
      .ks_next_i(ks_next_i)
   );

   always #5 clk = ~clk;

   // ---------------- AES reference pieces ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box: a^254 (GF inverse, 0 -> 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x = a;
      logic [7:0] r = 8'h01;
      logic [7:0] b;
      for (int i = 1; i < 8; i++) begin
         x = gmul(x, x);
         r = gmul(r, x);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input logic last);
      logic [7:0]   a[16];
      logic [7:0]   b[16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            logic [7:0] x0, x1, x2, x3;
            x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
            a[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
            a[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
            a[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
            a[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
         end
      end else begin
         for (int i = 0; i < 16; i++) a[i] = b[i];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
      return o ^ k;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   always_comb ks_next_i    = key_step(ks_key_o, ks_rcon_o);
   always_comb rnd_result_i = aes_round(rnd_state_o, rnd_key_o, rnd_last_o);

   // ---------------- helpers ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ec);
      exp_q.push_back(ec);
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      check("accept_in_ready_low", 128'(in_ready), 128'(0));
   endtask

   task automatic wait_done(input bit probe);
      int           lat = 0;
      logic [127:0] e;
      while (!out_valid && lat < 50) begin
         if (probe && lat < 10) begin
            check($sformatf("rcon_r%0d", lat + 1), 128'(ks_rcon_o), 128'(rcon_t[lat]));
            check($sformatf("last_r%0d", lat + 1), 128'(rnd_last_o), 128'(lat == 9));
         end
         tick();
         lat++;
      end
      check("latency", 128'(lat), 128'(10));
      if (probe) check("rcon_zero_done", 128'(ks_rcon_o), 128'(0));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      check("ciphertext", encrypted, e);
   endtask

   task automatic release_out;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_out_valid", 128'(out_valid), 128'(0));
      check("release_in_ready", 128'(in_ready), 128'(1));
   endtask

   // watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rcon_t[0] = 8'h01; rcon_t[1] = 8'h02; rcon_t[2] = 8'h04; rcon_t[3] = 8'h08;
      rcon_t[4] = 8'h10; rcon_t[5] = 8'h20; rcon_t[6] = 8'h40; rcon_t[7] = 8'h80;
      rcon_t[8] = 8'h1b; rcon_t[9] = 8'h36;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      plaintext = '0; key = '0;
      tick(); tick();
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_encrypted", encrypted, 128'(0));
      check("rst_rnd_state", rnd_state_o, 128'(0));
      check("rst_rnd_key", rnd_key_o, 128'(0));
      check("rst_ks_rcon", 128'(ks_rcon_o), 128'(0));
      rst_n = 1'b1;
      tick();

      // vector 1 with Rcon / last-round probing
      send(PT1, K1, CT1);
      wait_done(1'b1);
      release_out();

      // vector 2
      send(PT2, K2, CT2);
      wait_done(1'b0);
      release_out();

      // backpressure: hold 20 cycles with a stray in_valid
      send(PT1, K1, CT1);
      wait_done(1'b0);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_encrypted", encrypted, CT1);
         check("hold_in_ready", 128'(in_ready), 128'(0));
      end
      check("hold_out_valid", 128'(out_valid), 128'(1));
      in_valid = 1'b0;
      release_out();
      send(PT2, K2, CT2);
      wait_done(1'b0);
      release_out();

      // reset in round 5, then vector 1 again
      send(PT1, K1, CT1);
      tick(); tick(); tick(); tick();
      check("round5_rcon", 128'(ks_rcon_o), 128'(8'h10));
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 128'(in_ready), 128'(1));
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_encrypted", encrypted, 128'(0));
      check("midrst_rnd_state", rnd_state_o, 128'(0));
      check("midrst_ks_key", ks_key_o, 128'(0));
      void'(exp_q.pop_front());
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_no_out", 128'(out_valid), 128'(0));
      send(PT1, K1, CT1);
      wait_done(1'b0);
      release_out();

`ifdef AES_ENC_CTRL_BLKCNT_EN
      rst_n = 1'b0;
      tick();
      check("blkcnt_rst", 128'(blk_cnt), 128'(0));
      rst_n = 1'b1;
      tick();
      send(PT1, K1, CT1); wait_done(1'b0); release_out();
      send(PT2, K2, CT2); wait_done(1'b0); release_out();
      send(PT1, K1, CT1); wait_done(1'b0); release_out();
      check("blkcnt_three", 128'(blk_cnt), 128'(3));
      rst_n = 1'b0;
      #1;
      check("blkcnt_clear", 128'(blk_cnt), 128'(0));
      tick();
      rst_n = 1'b1;
      tick();
`endif

      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
